// File: rtl/mem_responder_if.sv
// Memory request/response bundle between the control unit and the memory responder.
// Latency: none, wires only.
// Backpressure: none here; the master holds its state until MemReady.
interface mem_responder_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [15:0]           Addr;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  MemReady;
  logic                  Busy;
  logic                  Error;

  // Control-unit side: issues strobes, consumes completion.
  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, MemReady, Busy, Error
  );

  // Memory side: accepts strobes, produces completion.
  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, MemReady, Busy, Error
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder servicing MemRead/MemWrite strobes from a multicycle control unit.
// Latency: LATENCY rising edges from acceptance to the MemReady pulse; one more edge back to IDLE.
// Backpressure: one request in flight; strobes seen while busy are dropped, not queued.
module mem_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 10,
  parameter int LATENCY    = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  mem_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter start value; WAIT runs LATENCY-1 down to 0 before entering DONE.
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [15:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  is_wr_q, is_wr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0]  mem_idx;
  logic                  in_range;
  logic                  mem_we;

  // High address bits must be zero; otherwise the access is timed but has no effect.
  assign mem_idx  = addr_q[ADDR_BITS-1:0];
  assign in_range = (addr_q[15:ADDR_BITS] == '0);

  assign bus.ReadData = rdata_q;
  assign bus.MemReady = ready_q;
  assign bus.Error    = err_q;
  assign bus.Busy     = (state_q != ST_IDLE);

  // Next-state, capture and completion logic for the single outstanding request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.MemRead ^ bus.MemWrite) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_INIT;
          addr_d  = bus.Addr;
          wdata_d = bus.WriteData;
          is_wr_d = bus.MemWrite;
        end else if (bus.MemRead && bus.MemWrite) begin
          // Conflicting strobes: reject, stay idle, flag for one cycle.
          err_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          err_d   = ~in_range;
          if (is_wr_q) begin
            mem_we = in_range;
          end else begin
            rdata_d = in_range ? mem[mem_idx] : '0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any request in flight.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage array write; contents are untouched by reset and a reset on the completing edge cancels the write.
  always_ff @(posedge CLK) begin
    if (!Reset && mem_we) begin
      mem[mem_idx] <= wdata_q;
    end
  end

endmodule
